mac_accumulator: RTL and testbench

- Downstream stage of the signed 16x16 multiplier.
- Captures each 32-bit product on the multiplier's valid strobe into a small FIFO and sums a programmed number of products into a wide signed accumulator.
- Presents the total on a valid/ready output handshake.
- The FIFO absorbs products that arrive while a previous sum waits to be accepted, because the multiplier cannot be back-pressured.

---
 rtl/mac_accumulator.sv | 156 +++++++++++++++
 tb/tb_mac_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Product FIFO plus signed accumulator summing a programmed count of multiplier products.
// Optional macro MAC_ACC_SAT_EN: saturating additions with a sticky sat flag (wrap-around otherwise).
module mac_accumulator #(
   parameter int PROD_W     = 32,
   parameter int ACC_W      = 40,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              overflow,
   output logic              sat
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t             state_reg, state_next;
   logic [PROD_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]     count_reg, count_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic [LEN_W-1:0]   rem_reg, rem_next;
   logic               ovf_reg, ovf_next;
   logic               sat_reg, sat_next;

   logic               full, push, pop, drop;
   logic [PROD_W-1:0]  head;
   logic [ACC_W-1:0]   head_ext;
   logic [ACC_W-1:0]   add_sum;
   logic               add_clamp;

   // Pop only happens in ACC, so an entry written this cycle is first visible next cycle.
   assign full     = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
   assign pop      = (state_reg == ACC) && (count_reg != '0);
   assign push     = prod_valid && (!full || pop);
   assign drop     = prod_valid && full && !pop;
   assign head     = mem[rd_ptr_reg];
   assign head_ext = ACC_W'(signed'(head));

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               mem[gi] <= prod;
            end
         end
      end
   endgenerate

`ifdef MAC_ACC_SAT_EN
   logic [ACC_W:0] wide_sum;
   always_comb begin
      wide_sum  = {acc_reg[ACC_W-1], acc_reg} + {head_ext[ACC_W-1], head_ext};
      add_sum   = wide_sum[ACC_W-1:0];
      add_clamp = 1'b0;
      // Disagreeing top bits of the extended sum mean the true result left the ACC_W range.
      if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
         add_clamp = 1'b1;
         add_sum   = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   always_comb begin
      add_sum   = acc_reg + head_ext;
      add_clamp = 1'b0;
   end
`endif

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      rem_next   = rem_reg;
      ovf_next   = ovf_reg | drop;
      sat_next   = sat_reg;
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (PTR_W+1)'(1);
         2'b01:   count_next = count_reg - (PTR_W+1)'(1);
         default: count_next = count_reg;
      endcase
      case (state_reg)
         IDLE: begin
            if (start) begin
               rem_next   = len;
               acc_next   = '0;
               ovf_next   = drop;
               sat_next   = 1'b0;
               state_next = (len == '0) ? HOLD : ACC;
            end
         end
         ACC: begin
            if (pop) begin
               acc_next = add_sum;
               rem_next = rem_reg - LEN_W'(1);
               sat_next = sat_reg | add_clamp;
               if (rem_reg == LEN_W'(1)) begin
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (sum_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         acc_reg    <= '0;
         rem_reg    <= '0;
         ovf_reg    <= 1'b0;
         sat_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         acc_reg   <= acc_next;
         rem_reg   <= rem_next;
         ovf_reg   <= ovf_next;
         sat_reg   <= sat_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   assign busy      = (state_reg != IDLE);
   assign sum       = acc_reg;
   assign sum_valid = (state_reg == HOLD);
   assign overflow  = ovf_reg;
`ifdef MAC_ACC_SAT_EN
   assign sat       = sat_reg;
`else
   assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a product model and a scoreboard of expected sums.
// A 33-bit accumulator is used so the five-product run exercises wrap or saturation.
module tb_mac_accumulator;

   localparam int PROD_W = 32;
   localparam int ACC_W  = 33;
   localparam int LEN_W  = 8;
   localparam int DEPTH  = 4;
   localparam int BIG    = 1073676289;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              prod_valid = 1'b0;
   logic [PROD_W-1:0] prod = '0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy;
   logic [ACC_W-1:0]  sum;
   logic              sum_valid;
   logic              sum_ready = 1'b0;
   logic              overflow;
   logic              sat;

   int compared = 0;
   int mismatched = 0;
   int model_q[$];
   logic [ACC_W-1:0] sb_q[$];
   logic model_sat = 1'b0;
   int pending_len = 0;
   int cyc = 0;

   mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .start(start), .len(len),
      .busy(busy), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
      .overflow(overflow), .sat(sat)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // The model FIFO only drops when full; overflow scenarios here occur while nothing pops.
   task automatic push_prod(input int v);
      prod_valid = 1'b1;
      prod = v;
      if (model_q.size() < DEPTH || busy && !sum_valid) model_q.push_back(v);
      tick();
      prod_valid = 1'b0;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      len = LEN_W'(n);
      pending_len = n;
      model_sat = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic expect_run();
      longint acc = 0;
      longint maxv = (longint'(1) <<< (ACC_W-1)) - 1;
      longint minv = -(longint'(1) <<< (ACC_W-1));
      for (int i = 0; i < pending_len; i++) begin
         acc = acc + longint'(model_q.pop_front());
`ifdef MAC_ACC_SAT_EN
         if (acc > maxv) begin acc = maxv; model_sat = 1'b1; end
         if (acc < minv) begin acc = minv; model_sat = 1'b1; end
`endif
      end
      sb_q.push_back(acc[ACC_W-1:0]);
   endtask

   task automatic wait_sum(input string tag, output int cycles);
      logic [ACC_W-1:0] exp;
      int n = 0;
      while (sum_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 64'(sum_valid), 64'd1);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      chk({tag, "_sum"}, 64'(sum), 64'(exp));
      $display("run %s: sum=%0d after %0d cycles", tag, sum, n);
      cycles = n;
   endtask

   task automatic accept(input string tag);
      logic [ACC_W-1:0] last;
      last = sum;
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(sum_valid), 64'd0);
      chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
      chk({tag, "_sum_kept"}, 64'(sum), 64'(last));
   endtask

   initial begin
      int cycles;
      logic [ACC_W-1:0] neg_exp;

      // Reset state
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_valid", 64'(sum_valid), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_sat", 64'(sat), 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // Basic: products arrive one per cycle while accumulating
      do_start(4);
      chk("basic_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) push_prod(BIG);
      expect_run();
      wait_sum("basic", cycles);
      chk("basic_const", 64'(sum), 64'd4294705156);
      accept("basic");

      // Mixed sign and zero, pre-buffered
      push_prod(-BIG);
      push_prod(0);
      push_prod(5);
      do_start(3);
      expect_run();
      wait_sum("mixed", cycles);
      chk("mixed_latency", 64'(cycles), 64'd3);
      neg_exp = ACC_W'(-64'sd1073676284);
      chk("mixed_const", 64'(sum), 64'(neg_exp));
      accept("mixed");

      // Backpressure in HOLD and FIFO overflow
      do_start(1);
      push_prod(100);
      expect_run();
      wait_sum("hold", cycles);
      for (int i = 1; i <= 4; i++) push_prod(10 * i);
      chk("ovf_before", 64'(overflow), 64'd0);
      push_prod(50);
      chk("ovf_after", 64'(overflow), 64'd1);
      chk("hold_valid", 64'(sum_valid), 64'd1);
      accept("hold");
      chk("ovf_sticky", 64'(overflow), 64'd1);
      do_start(4);
      chk("ovf_clear", 64'(overflow), 64'd0);
      expect_run();
      wait_sum("drain", cycles);
      chk("drain_latency", 64'(cycles), 64'd4);
      accept("drain");

      // len = 0 leaves buffered data alone
      push_prod(9);
      do_start(0);
      expect_run();
      wait_sum("len0", cycles);
      chk("len0_latency", 64'(cycles), 64'd0);
      accept("len0");
      do_start(1);
      expect_run();
      wait_sum("after_len0", cycles);
      accept("after_len0");

      // Asynchronous reset in the middle of accumulation
      for (int i = 1; i <= 4; i++) push_prod(i);
      do_start(4);
      tick();
      tick();
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_sum", 64'(sum), 64'd0);
      chk("arst_valid", 64'(sum_valid), 64'd0);
      chk("arst_ovf", 64'(overflow), 64'd0);
      model_q.delete();
      tick();
      rst = 1'b1;
      tick();
      push_prod(7);
      do_start(1);
      expect_run();
      wait_sum("post_rst", cycles);
      chk("post_rst_const", 64'(sum), 64'd7);
      accept("post_rst");

      // Five large products overflow a 33-bit accumulator
      do_start(5);
      for (int i = 0; i < 5; i++) push_prod(BIG);
      expect_run();
      wait_sum("big5", cycles);
      chk("big5_sat", 64'(sat), 64'(model_sat));
      accept("big5");
      do_start(0);
      chk("sat_clear", 64'(sat), 64'd0);
      expect_run();
      wait_sum("final", cycles);
      accept("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
